// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit engine of the UART. Pops bytes from the TX FIFO read port and
// serialises each one onto the tx line:
// start bit, 5..8 data bits (LSB first), optional parity bit, 1 or 2 stop bits.
// Bit timing comes from an internal prescaler. The frame configuration is
// captured together with the byte, so config changes mid-frame have no effect.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous reset, active-high
//   en          in   transmitter enable (a running frame always completes)
//   prescale    in   bit period minus one, in clk cycles
//   wlen        in   data bits per frame: 0=5, 1=6, 2=7, 3=8
//   parity_en   in   insert a parity bit
//   parity_odd  in   1 = odd parity, 0 = even parity
//   stop2       in   1 = two stop bits, 0 = one stop bit
//   fifo_empty  in   TX FIFO empty flag
//   fifo_rdata  in   TX FIFO head word (bits [7:0] transmitted)
//   fifo_rd     out  pop strobe, one cycle per byte
//   tx          out  serial line, registered, idles high
//   busy        out  frame in progress
//   done        out  pulse on the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DW = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [PW-1:0] prescale,
    input  logic [1:0]    wlen,
    input  logic          parity_en,
    input  logic          parity_odd,
    input  logic          stop2,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_rd,
    output logic          tx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity over the low wl+5 bits of the byte, inverted for odd parity.
    function automatic logic calc_parity(input logic [7:0] d,
                                         input logic [1:0] wl,
                                         input logic       odd);
        logic [7:0] mask;
        case (wl)
            2'd0:    mask = 8'h1F;
            2'd1:    mask = 8'h3F;
            2'd2:    mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return (^(d & mask)) ^ odd;
    endfunction

    state_t        r_state;
    logic [PW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_data;
    logic [PW-1:0] r_prescale;
    logic [1:0]    r_wlen;
    logic          r_parity_en;
    logic          r_stop2;
    logic          r_parity_bit;
    logic          r_tx;

    state_t        w_state_next;
    logic [PW-1:0] w_cnt_next;
    logic [2:0]    w_idx_next;
    logic          w_bit_end;
    logic          w_last_data;
    logic          w_last_stop;
    logic          w_load;
    logic          w_done;
    logic          w_busy;
    logic          w_tx_next;

    // Equality compare keeps prescale = all-ones from wrapping the counter.
    assign w_bit_end   = (r_cnt == r_prescale);
    assign w_last_data = (r_bit_idx == (3'd4 + {1'b0, r_wlen}));
    assign w_last_stop = w_bit_end && ((!r_stop2) || (r_bit_idx == 3'd1));

    // State register, bit timing counters, frame capture and the tx flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_data       <= 8'h00;
            r_prescale   <= '0;
            r_wlen       <= 2'd0;
            r_parity_en  <= 1'b0;
            r_stop2      <= 1'b0;
            r_parity_bit <= 1'b0;
            r_tx         <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_idx_next;
            r_tx      <= w_tx_next;
            if (w_load) begin
                r_data       <= fifo_rdata[7:0];
                r_prescale   <= prescale;
                r_wlen       <= wlen;
                r_parity_en  <= parity_en;
                r_stop2      <= stop2;
                r_parity_bit <= calc_parity(fifo_rdata[7:0], wlen, parity_odd);
            end else begin
                r_data       <= r_data;
                r_prescale   <= r_prescale;
                r_wlen       <= r_wlen;
                r_parity_en  <= r_parity_en;
                r_stop2      <= r_stop2;
                r_parity_bit <= r_parity_bit;
            end
        end
    end

    // Next state, cycle counter and bit index.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_bit_idx;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_idx_next = 3'd0;
                if (w_load) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                    w_cnt_next   = '0;
                    w_idx_next   = 3'd0;
                end else begin
                    w_cnt_next = r_cnt + PW'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (w_last_data) begin
                        w_state_next = r_parity_en ? ST_PARITY : ST_STOP;
                        w_idx_next   = 3'd0;
                    end else begin
                        w_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + PW'(1);
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                    w_cnt_next   = '0;
                    w_idx_next   = 3'd0;
                end else begin
                    w_cnt_next = r_cnt + PW'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (w_last_stop) begin
                        // A waiting byte starts immediately: no idle gap.
                        w_state_next = w_load ? ST_START : ST_IDLE;
                        w_idx_next   = 3'd0;
                    end else begin
                        w_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + PW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_idx_next   = 3'd0;
            end
        endcase
    end

    // Outputs: pop strobe, done pulse, busy, and the line level for next cycle.
    always_comb begin
        w_load    = 1'b0;
        w_done    = 1'b0;
        w_busy    = (r_state != ST_IDLE);
        w_tx_next = 1'b1;
        // Reset suppresses the pop so an aborted frame never consumes a byte.
        if (!rst && en && !fifo_empty &&
            ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_last_stop))) begin
            w_load = 1'b1;
        end else begin
            w_load = 1'b0;
        end
        if (!rst && (r_state == ST_STOP) && w_last_stop) begin
            w_done = 1'b1;
        end else begin
            w_done = 1'b0;
        end
        // tx is registered one cycle ahead so it lines up with r_state.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_data[w_idx_next];
            ST_PARITY: w_tx_next = r_parity_bit;
            ST_STOP:   w_tx_next = 1'b1;
            default:   w_tx_next = 1'b1;
        endcase
    end

    assign fifo_rd = w_load;
    assign done    = w_done;
    assign busy    = w_busy;
    assign tx      = r_tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] prescale;
    logic [1:0]  wlen;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_rd;
    logic        tx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int rd_count = 0;
    int rd_before;

    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;

    uart_tx_serializer #(.DW(8), .PW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .prescale   (prescale),
        .wlen       (wlen),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small FIFO model feeding the read port
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_ptr   <= rd_ptr + 4'd1;
            rd_count <= rd_count + 1;
        end
    end

    // A pop is never allowed against an empty FIFO
    always @(negedge clk) begin
        assert (!(fifo_rd && fifo_empty)) else begin
            bad = bad + 1;
            $error("FAIL rd_when_empty observed=1 expected=0");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Called on a negedge where fifo_rd is expected; checks every cycle of
    // nbits bit periods. exp[i] is tx for bit i, dmask[i] marks bits whose
    // last cycle must carry done. At cycle number mid_at, en drops and wlen changes.
    task automatic run_frame(input string tag, input int p, input int nbits,
                             input logic [31:0] exp, input logic [31:0] dmask,
                             input int mid_at);
        int k;
        k = 0;
        #1;
        chk({tag, "_rd"}, {31'd0, fifo_rd}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c <= p; c++) begin
                @(negedge clk);
                chk({tag, "_tx"}, {31'd0, tx}, {31'd0, exp[i]});
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                chk({tag, "_done"}, {31'd0, done},
                    {31'd0, (dmask[i] && (c == p))});
                if (k == mid_at) begin
                    en   = 1'b0;
                    wlen = 2'd0;
                end
                k++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; prescale = 16'd3; wlen = 2'd3;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 8N1, 0xA5, 4 cycles per bit
        push(8'hA5); en = 1'b1;
        rd_before = rd_count;
        run_frame("a5", 3, 10, {22'd0, 1'b1, 8'hA5, 1'b0}, 32'h200, -1);
        @(negedge clk);
        chk("a5_idle_busy", {31'd0, busy}, 32'd0);
        chk("a5_idle_tx", {31'd0, tx}, 32'd1);
        chk("a5_pops", rd_count - rd_before, 32'd1);

        // 5 data bits 0x13 with even parity: bits 1,1,0,0,1 parity 1
        prescale = 16'd1; wlen = 2'd0; parity_en = 1'b1; parity_odd = 1'b0;
        push(8'h13);
        run_frame("p5e", 1, 8, {24'd0, 1'b1, 1'b1, 5'h13, 1'b0}, 32'h80, -1);
        @(negedge clk);
        chk("p5e_idle", {31'd0, busy}, 32'd0);

        // Odd parity: parity bit 0
        parity_odd = 1'b1;
        push(8'h13);
        run_frame("p5o", 1, 8, {24'd0, 1'b1, 1'b0, 5'h13, 1'b0}, 32'h80, -1);
        @(negedge clk);
        chk("p5o_idle", {31'd0, busy}, 32'd0);

        // Two stop bits, even parity; upper bits of 0xF3 are not sent
        parity_odd = 1'b0; stop2 = 1'b1;
        push(8'hF3);
        run_frame("s2", 1, 9, {23'd0, 2'b11, 1'b1, 5'h13, 1'b0}, 32'h100, -1);
        @(negedge clk);
        chk("s2_idle", {31'd0, busy}, 32'd0);

        // Back-to-back 0x55 then 0x0F, 1-cycle bits, no gap between frames
        prescale = 16'd0; wlen = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
        rd_before = rd_count;
        push(8'h55); push(8'h0F);
        run_frame("b2b", 0, 20,
                  {12'd0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0}, 32'h80200, -1);
        @(negedge clk);
        chk("b2b_pops", rd_count - rd_before, 32'd2);
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        chk("b2b_idle_tx", {31'd0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        chk("b2b_still_idle", {31'd0, busy}, 32'd0);

        // en dropped and wlen changed during DATA of 0xC3; 0xF0 waits in FIFO
        prescale = 16'd1;
        rd_before = rd_count;
        push(8'hC3); push(8'hF0);
        run_frame("c3", 1, 10, {22'd0, 1'b1, 8'hC3, 1'b0}, 32'h200, 6);
        repeat (5) begin
            @(negedge clk);
            chk("c3_no_rd", {31'd0, fifo_rd}, 32'd0);
            chk("c3_idle_busy", {31'd0, busy}, 32'd0);
        end
        chk("c3_pops", rd_count - rd_before, 32'd1);

        // Reset during data bit 3 of 0xF0 (bit 3 is 0), 3 cycles per bit
        prescale = 16'd2; wlen = 2'd3; en = 1'b1;
        #1;
        chk("rs_rd", {31'd0, fifo_rd}, 32'd1);
        push(8'h3C);
        repeat (14) @(negedge clk);
        chk("rs_pre_tx", {31'd0, tx}, 32'd0);
        chk("rs_pre_busy", {31'd0, busy}, 32'd1);
        rd_before = rd_count;
        rst = 1'b1;
        @(negedge clk);
        chk("rs_tx", {31'd0, tx}, 32'd1);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_rd0", {31'd0, fifo_rd}, 32'd0);
        chk("rs_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("rs_hold_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rs_no_pop", rd_count - rd_before, 32'd0);
        rst = 1'b0;
        run_frame("rs3c", 2, 10, {22'd0, 1'b1, 8'h3C, 1'b0}, 32'h200, -1);
        @(negedge clk);
        chk("rs3c_idle", {31'd0, busy}, 32'd0);

        // Empty FIFO with en=1 for 100 cycles
        rd_before = rd_count;
        repeat (100) begin
            @(negedge clk);
            chk("emp_rd", {31'd0, fifo_rd}, 32'd0);
            chk("emp_tx", {31'd0, tx}, 32'd1);
            chk("emp_busy", {31'd0, busy}, 32'd0);
        end
        chk("emp_pops", rd_count - rd_before, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
